// File: rtl/operand2_pipe.sv
// operand2_pipe: forms the second ALU operand from a register value, a raw
// 22-bit immediate and a 4-bit operand-select code. The formed operand is
// queued in a small FIFO (DEPTH entries) with valid/ready handshakes on
// both sides.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   flush      synchronous discard of all buffered entries
//   in_valid   producer offers a request
//   in_ready   block can accept (registered, no path from out_ready)
//   in_r       register-file operand
//   in_imm     raw immediate field
//   in_is      operand-select code
//   out_valid  head entry valid
//   out_ready  consumer takes the head entry
//   out_n      formed operand at head
//   out_is     select code captured with the head entry
//   count      number of occupied entries
module operand2_pipe #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 2,
  localparam int SH_W   = (DATA_W == 64) ? 6 : 5,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_r,
  input  logic [21:0]       in_imm,
  input  logic [3:0]        in_is,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_n,
  output logic [3:0]        out_is,
  output logic [CW-1:0]     count
);

  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_w
    $error("operand2_pipe: DATA_W must be 32 or 64");
  end
  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_d
    $error("operand2_pipe: DEPTH must be a power of two in 2..16");
  end

  logic [DATA_W-1:0] n_d;
  logic [DATA_W-1:0] n_mem_q [DEPTH];
  logic [3:0]        is_mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     cnt_q;
  // Low while in reset, high from the first edge after release; keeps
  // in_ready low during reset without touching the count logic.
  logic              rdy_q;
  logic              push, pop;

  // Operand formation
  always_comb begin
    n_d = '0;
    casez (in_is)
      4'b00??:                   n_d = DATA_W'({in_imm, 10'b0});
      4'b01??:                   n_d = {{(DATA_W-22){in_imm[21]}}, in_imm};
      4'b1000, 4'b1100, 4'b1110: n_d = in_r;
      4'b1001, 4'b1101, 4'b1111: n_d = {{(DATA_W-13){in_imm[12]}}, in_imm[12:0]};
      4'b1010:                   n_d = DATA_W'(in_r[SH_W-1:0]);
      4'b1011:                   n_d = DATA_W'(in_imm[SH_W-1:0]);
      default:                   n_d = '0;
    endcase
  end

  assign in_ready  = rdy_q && (cnt_q != CW'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = cnt_q;
  assign out_n     = n_mem_q[rptr_q];
  assign out_is    = is_mem_q[rptr_q];

  // Storage is not reset; only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      n_mem_q[wptr_q]  <= n_d;
      is_mem_q[wptr_q] <= in_is;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      rdy_q  <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        // DEPTH is a power of two, so natural pointer overflow wraps.
        if (push) wptr_q <= wptr_q + AW'(1);
        if (pop)  rptr_q <= rptr_q + AW'(1);
        case ({push, pop})
          2'b10:   cnt_q <= cnt_q + CW'(1);
          2'b01:   cnt_q <= cnt_q - CW'(1);
          default: cnt_q <= cnt_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_operand2_pipe.sv
module tb_operand2_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [63:0] in_r;
  logic [21:0] in_imm;
  logic [3:0]  in_is;

  logic        rdy32, ov32, rdy64, ov64;
  logic [31:0] n32;
  logic [63:0] n64;
  logic [3:0]  is32, is64;
  logic [1:0]  cnt32;
  logic [2:0]  cnt64;

  always #5 clk = ~clk;

  operand2_pipe #(.DATA_W(32), .DEPTH(2)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_r(in_r[31:0]), .in_imm(in_imm), .in_is(in_is), .out_valid(ov32),
    .out_ready(out_ready), .out_n(n32), .out_is(is32), .count(cnt32));

  operand2_pipe #(.DATA_W(64), .DEPTH(4)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_r(in_r), .in_imm(in_imm), .in_is(in_is), .out_valid(ov64),
    .out_ready(out_ready), .out_n(n64), .out_is(is64), .count(cnt64));

  // Reference model: queues of {is, operand}
  logic [67:0] q32[$];
  logic [67:0] q64[$];
  bit          rdy_m;
  int          n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] form(input logic [63:0] r, input logic [21:0] imm,
                                       input logic [3:0] is, input int w);
    longint v;
    case (is)
      0, 1, 2, 3:    v = longint'(imm) * 1024;
      4, 5, 6, 7:    v = (imm >= 22'd2097152) ? longint'(imm) - 4194304 : longint'(imm);
      8, 12, 14:     v = r;
      9, 13, 15:     v = ((imm % 8192) >= 4096) ? longint'(imm % 8192) - 8192 : longint'(imm % 8192);
      10:            v = (w == 64) ? longint'(r % 64) : longint'(r % 32);
      default:       v = (w == 64) ? longint'(imm % 64) : longint'(imm % 32);
    endcase
    return (w == 32) ? (v & 64'hFFFF_FFFF) : v;
  endfunction

  task automatic check_all();
    chk("cnt32", 64'(cnt32), 64'(q32.size()));
    chk("ov32",  64'(ov32),  64'(q32.size() != 0));
    chk("rdy32", 64'(rdy32), 64'(rdy_m && q32.size() != 2));
    chk("cnt64", 64'(cnt64), 64'(q64.size()));
    chk("ov64",  64'(ov64),  64'(q64.size() != 0));
    chk("rdy64", 64'(rdy64), 64'(rdy_m && q64.size() != 4));
    if (q32.size() != 0) begin
      chk("n32",  64'(n32),  64'(q32[0][31:0]));
      chk("is32", 64'(is32), 64'(q32[0][67:64]));
    end
    if (q64.size() != 0) begin
      chk("n64",  n64,       q64[0][63:0]);
      chk("is64", 64'(is64), 64'(q64[0][67:64]));
    end
  endtask

  // Drive one cycle of stimulus, advance the model at the edge, check at negedge.
  task automatic cyc(input bit v, input bit ordy, input bit fl,
                     input logic [63:0] r, input logic [21:0] imm, input logic [3:0] is);
    bit push32, pop32, push64, pop64;
    in_valid = v; out_ready = ordy; flush = fl; in_r = r; in_imm = imm; in_is = is;
    push32 = v && rdy_m && q32.size() < 2;
    push64 = v && rdy_m && q64.size() < 4;
    pop32  = ordy && q32.size() > 0;
    pop64  = ordy && q64.size() > 0;
    @(posedge clk);
    if (fl) begin
      q32.delete(); q64.delete();
    end else begin
      if (pop32)  void'(q32.pop_front());
      if (pop64)  void'(q64.pop_front());
      if (push32) q32.push_back({is, form(r, imm, is, 32)});
      if (push64) q64.push_back({is, form(r, imm, is, 64)});
    end
    rdy_m = 1'b1;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; flush = 0; in_valid = 0; out_ready = 0;
    in_r = '0; in_imm = '0; in_is = '0; rdy_m = 0;
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    #1 chk("rdy_before_edge", 64'(rdy32), 64'd0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rdy_after_rel", 64'(rdy32), 64'd1);

    // Immediate-shift case
    cyc(1, 0, 0, 0, 22'h3FFFFF, 4'b0000);
    chk("e037_n32", 64'(n32), 64'hFFFFFC00);
    chk("e037_is32", 64'(is32), 64'd0);
    cyc(0, 1, 0, 0, 0, 0);

    // Sign-extension cases (64-bit)
    cyc(1, 0, 0, 0, 22'h200000, 4'b0101);
    chk("e038a_n64", n64, 64'hFFFFFFFFFFE00000);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 22'h001FFF, 4'b1001);
    chk("e038b_n64", n64, 64'hFFFFFFFFFFFFFFFF);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 22'h3F0FFF, 4'b1101);
    chk("e038c_n64", n64, 64'h0000000000000FFF);
    cyc(0, 1, 0, 0, 0, 0);

    // Shift-count cases
    cyc(1, 0, 0, 64'hFFFFFFFF_FFFFFFE7, 0, 4'b1010);
    chk("e039a_n32", 64'(n32), 64'h7);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 22'h00007F, 4'b1011);
    chk("e039b_n64", n64, 64'h3F);
    cyc(0, 1, 0, 0, 0, 0);

    // Backpressure on the DEPTH=2 instance
    cyc(1, 0, 0, 64'hA, 0, 4'b1000);
    cyc(1, 0, 0, 64'hB, 0, 4'b1000);
    chk("full_cnt", 64'(cnt32), 64'd2);
    chk("full_rdy", 64'(rdy32), 64'd0);
    cyc(1, 0, 0, 64'hC, 0, 4'b1000);
    chk("held_n32", 64'(n32), 64'hA);
    for (int i = 0; i < 6; i++) cyc(q32.size() < 3 && i < 2, 1, 0, 64'hC, 0, 4'b1000);
    chk("drained", 64'(cnt32), 64'd0);

    // Simultaneous push/pop at count 1, then flush with a push offered
    cyc(1, 0, 0, 64'h11, 0, 4'b1100);
    cyc(1, 1, 0, 64'h22, 0, 4'b1110);
    chk("pp_cnt", 64'(cnt32), 64'd1);
    chk("pp_n32", 64'(n32), 64'h22);
    cyc(1, 0, 1, 64'h33, 0, 4'b1000);
    chk("flush_cnt", 64'(cnt32), 64'd0);
    chk("flush_ov", 64'(ov32), 64'd0);

    // Asynchronous reset between edges with two entries buffered
    cyc(1, 0, 0, 64'h44, 0, 4'b1000);
    cyc(1, 0, 0, 64'h55, 0, 4'b1000);
    #2 rst_n = 1'b0;
    #1 chk("arst_ov", 64'(ov32), 64'd0);
    chk("arst_cnt", 64'(cnt32), 64'd0);
    chk("arst_rdy", 64'(rdy32), 64'd0);
    q32.delete(); q64.delete(); rdy_m = 0;
    #1 rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    chk("arst_rdy_after", 64'(rdy32), 64'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cyc(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 32) == 0,
          {$urandom, $urandom}, 22'($urandom), 4'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
